maxpool_relu_32_2: RTL
======================

# maxpool_relu_32_2

Streaming ReLU plus 1-D max-pool stage placed directly downstream of the conv_96_65_16_16 layer. It consumes the conv layer's signed T-bit output stream through a valid/ready handshake. For every K consecutive samples it emits one pooled sample: the signed maximum of the window, passed through a ReLU. A 32-sample conv output vector with K=2 becomes 16 outputs, fed to the next layer through the same handshake.

## Interface
- T, 16: data width in bits; two's-complement signed.
- N, 32: samples per input vector. Elaboration error if N % K != 0.
- K, 2: pooling window size. Stride equals K, so windows do not overlap. Legal range K ≥ 1; K=1 degenerates to ReLU-only.
- RELU, 1: 1 clamps negative pooled results to 0; 0 passes the signed maximum through.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- x_data  input  T  signed input sample from the conv stage.
- x_valid  input  1  x_data is valid.
- x_ready  output  1  block accepts x_data this cycle.
- y_data  output  T  signed pooled and ReLU'd output.
- y_valid  output  1  y_data is valid.
- y_ready  input  1  downstream accepts y_data this cycle.

## Operation
- Transfer rule: an input transfer occurs when x_valid && x_ready at a rising edge. An output transfer occurs when y_valid && y_ready at a rising edge.
- State:
  - win_cnt, range 0..K-1: position within the current window.
  - acc: T-bit signed running maximum.
  - out register: y_data / y_valid.
  - vec_cnt, range 0..N/K-1: output index within the vector. Diagnostic only; wraps to 0 after N/K outputs.
- Accepted sample, not completing a window (win_cnt < K-1):
  - win_cnt == 0: acc <= x_data.
  - otherwise: acc <= max(acc, x_data), signed compare.
  - win_cnt <= win_cnt + 1.
- Accepted sample completing a window (win_cnt == K-1):
  - m = max(acc, x_data). For K=1, m = x_data.
  - y_data <= (RELU && m < 0) ? 0 : m.
  - y_valid <= 1; win_cnt <= 0; vec_cnt advances.
- Arithmetic: compare only, no add, so no overflow is possible. 0x8000 is a legal minimum and 0x7fff a legal maximum.
- Windows never straddle vectors because N % K == 0. No vector-boundary logic is needed beyond the wrap of win_cnt.

## Timing
- Reset (reset==0 at a rising edge): y_valid=0, y_data=0, win_cnt=0, vec_cnt=0, acc=0.
  - Reset has priority over all transfers in that cycle.
  - Reset mid-window discards the partial window; the first sample after reset starts a new window.
  - Reset with y_valid=1 drops the pending output.
- x_ready is combinational: x_ready = (win_cnt != K-1) || !y_valid || y_ready.
  - Non-completing samples are always accepted, even under backpressure, because they touch only acc.
  - The completing sample stalls only while the output register holds an undrained value.
- y_valid clears on an output transfer, unless a window completes in the same cycle. In that case y_data reloads and y_valid stays 1, with no bubble.
- Latency: y_valid rises one cycle after the edge that accepts the K-th sample of a window.
- Throughput: one input per cycle sustained with y_ready held high; one output every K inputs.
- y_data and y_valid are held stable while y_valid && !y_ready.
- x_data is ignored when x_valid=0; it may be X.

## Test plan
- Basic pooling (N=32, K=2, RELU=1): inputs 3, -5, -7, -2, 0x7fff, 0x8000 -> outputs 0x0003, 0x0000, 0x7fff; each y_valid exactly one cycle after its second input is accepted, with y_ready=1.
- RELU=0 (same inputs) -> outputs 0x0003, 0xfffe, 0x7fff. Also all-0x8000 windows -> 0x8000.
- Backpressure: hold y_ready=0 after the first output.
  - The next window's first sample is accepted with x_ready=1.
  - On the completing sample x_ready=0 and y_data stays 0x0003 until y_ready=1.
  - In that y_ready=1 cycle, x_ready=1 and the second output loads with no idle cycle.
- Mid-window reset: feed 100, pulse reset=0 for one cycle, then feed -1, 50 -> single output 0x0032; 100 never appears. After reset, y_valid=0 and y_data=0.
- Random-handshake system test: 3328 conv-stage outputs (104 vectors × 32) with random x_valid and y_ready -> 1664 outputs matching a reference model, zero errors, none dropped or duplicated; vec_cnt returns to 0 every 16 outputs.

Source files
------------

// File: rtl/maxpool_relu_32_2.sv
// Streaming ReLU + non-overlapping 1-D max-pool stage.
// Every K accepted samples produce one pooled output: the signed maximum of
// the window, optionally clamped at zero. Valid/ready handshake on both sides.
module maxpool_relu_32_2 #(
  parameter int T    = 16,
  parameter int N    = 32,
  parameter int K    = 2,
  parameter int RELU = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  // Counter widths stay at least one bit so K=1 and N/K=1 still elaborate.
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int VW = ((N / K) > 1) ? $clog2(N / K) : 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(K - 1);
  localparam logic [VW-1:0] VEC_LAST = VW'((N / K) - 1);

  // Reject illegal geometries at elaboration time.
  if (K < 1) begin : g_bad_k
    $error("maxpool_relu_32_2: K must be at least 1");
  end else if (N % K != 0) begin : g_bad_nk
    $error("maxpool_relu_32_2: N must be a multiple of K");
  end

  logic [CW-1:0]       win_cnt;
  logic [VW-1:0]       vec_cnt;
  logic signed [T-1:0] acc;
  logic signed [T-1:0] win_max;
  logic signed [T-1:0] pooled;
  logic                win_last;
  logic                x_fire;
  logic                y_fire;

  // Handshake decode and the combinational max / ReLU datapath.
  always_comb begin
    win_last = (win_cnt == WIN_LAST);
    // Only the completing sample needs the output register; it may proceed
    // when the register is empty or being drained this very cycle.
    x_ready  = !win_last || !y_valid || y_ready;
    x_fire   = x_valid && x_ready;
    y_fire   = y_valid && y_ready;
    if (K == 1) begin
      win_max = x_data;
    end else begin
      win_max = (x_data > acc) ? x_data : acc;
    end
    pooled = ((RELU != 0) && win_max[T-1]) ? '0 : win_max;
  end

  // Window accumulation, output register and diagnostic vector counter.
  // NOTE: every register here is state, so it is written with non-blocking
  // assignments; a blocking write would let later statements see the new value
  // within the same edge and break the register semantics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: reset is synchronous and covers every register, including acc;
      // a partial window is simply discarded.
      win_cnt <= '0;
      vec_cnt <= '0;
      acc     <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      // Drain first; a completing window below overrides this with no bubble.
      if (y_fire) begin
        y_valid <= 1'b0;
      end
      if (x_fire) begin
        if (win_last) begin
          y_data  <= pooled;
          y_valid <= 1'b1;
          win_cnt <= '0;
          vec_cnt <= (vec_cnt == VEC_LAST) ? '0 : vec_cnt + VW'(1);
        end else begin
          acc     <= (win_cnt == '0) ? x_data : win_max;
          win_cnt <= win_cnt + CW'(1);
        end
      end
    end
  end

endmodule
